// File: rtl/mem_link_pkg.sv
// rtl/mem_link_pkg.sv - shared constants and tag decode for the tagged memory link
package mem_link_pkg;

    localparam int NDEST     = 12;
    localparam int TAG_W     = 4;
    localparam int PAYLOAD_W = 44;
    localparam int STREAM_W  = 48;

    localparam logic [TAG_W-1:0] TAG_IDLE0 = 4'b0000;
    localparam logic [TAG_W-1:0] TAG_IDLE1 = 4'b1111;

    typedef struct packed {
        logic       valid;
        logic       illegal;
        logic [3:0] index;
    } tag_dec_t;

    // Tags 1010 and 1110 are holes in the map; everything else is idle or a destination.
    function automatic tag_dec_t decode_tag(input logic [TAG_W-1:0] tag);
        tag_dec_t d;
        d = '0;
        case (tag)
            TAG_IDLE0, TAG_IDLE1: d = '0;
            4'b1001: begin d.valid = 1'b1; d.index = 4'd8;  end
            4'b1011: begin d.valid = 1'b1; d.index = 4'd9;  end
            4'b1100: begin d.valid = 1'b1; d.index = 4'd10; end
            4'b1101: begin d.valid = 1'b1; d.index = 4'd11; end
            4'b1010, 4'b1110: d.illegal = 1'b1;
            default: begin d.valid = 1'b1; d.index = tag - 4'd1; end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_demux_cnt.sv
// rtl/mem_demux_cnt.sv - per-destination saturating write counter with overflow flag
module mem_demux_cnt #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr,
    output logic              full,
    output logic              ovf
);

    localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] CNT_FULL = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W:0] cnt;

    assign addr = cnt[ADDR_W-1:0];
    assign full = (cnt == CNT_FULL);

    // A clear coincident with an increment means that word took address 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            cnt <= inc ? CNT_ONE : '0;
            ovf <= 1'b0;
        end else if (inc) begin
            if (full)
                ovf <= 1'b1;
            else
                cnt <= cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/mem_demux.sv
// rtl/mem_demux.sv - routes tagged link words to 12 destination write ports per BX
module mem_demux
    import mem_link_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2:0]           BX,
    input  logic [STREAM_W-1:0]  mem_dat_stream,
    output logic [NDEST-1:0]     wr_en,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [PAYLOAD_W-1:0] wr_dat,
    output logic [2:0]           wr_bx,
    output logic [NDEST-1:0]     overflow,
    output logic                 err_tag
);

    logic [STREAM_W-1:0] dat_q;
    logic [2:0]          bx_q;
    logic [2:0]          bx_last;
    logic                s1_vld;
    logic                bx_seen;
    logic                new_bx;
    tag_dec_t            dec;

    logic [NDEST-1:0]    sel;
    logic [NDEST-1:0]    full;
    logic [NDEST-1:0]    wr_nxt;
    logic [ADDR_W-1:0]   cnt_addr [NDEST];
    logic [ADDR_W-1:0]   addr_nxt;

    // s1_vld keeps the reset contents of stage 1 from being processed as a word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dat_q  <= '0;
            bx_q   <= '0;
            s1_vld <= 1'b0;
        end else begin
            dat_q  <= mem_dat_stream;
            bx_q   <= BX;
            s1_vld <= 1'b1;
        end
    end

    assign dec    = decode_tag(dat_q[STREAM_W-1 -: TAG_W]);
    assign new_bx = s1_vld && (!bx_seen || (bx_q != bx_last));

    for (genvar i = 0; i < NDEST; i++) begin : g_dest
        assign sel[i]    = s1_vld && dec.valid && (dec.index == 4'(i));
        assign wr_nxt[i] = sel[i] && (new_bx || !full[i]);

        mem_demux_cnt #(.ADDR_W(ADDR_W)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (new_bx),
            .inc   (sel[i]),
            .addr  (cnt_addr[i]),
            .full  (full[i]),
            .ovf   (overflow[i])
        );
    end

    always_comb begin
        addr_nxt = '0;
        for (int i = 0; i < NDEST; i++) begin
            if (wr_nxt[i])
                addr_nxt = new_bx ? '0 : cnt_addr[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= '0;
            wr_addr <= '0;
            wr_dat  <= '0;
            wr_bx   <= '0;
            err_tag <= 1'b0;
            bx_last <= '0;
            bx_seen <= 1'b0;
        end else begin
            wr_en   <= wr_nxt;
            err_tag <= s1_vld && dec.illegal;
            if (s1_vld)
                wr_bx <= bx_q;
            if (|wr_nxt) begin
                wr_addr <= addr_nxt;
                wr_dat  <= dat_q[PAYLOAD_W-1:0];
            end
            if (new_bx) begin
                bx_last <= bx_q;
                bx_seen <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_demux.sv
// tb/tb_mem_demux.sv - directed self-checking bench for mem_demux
module tb_mem_demux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  bx;
    logic [47:0] stream;

    logic [11:0] wr_en, s_wr_en;
    logic [5:0]  wr_addr;
    logic [1:0]  s_wr_addr;
    logic [43:0] wr_dat, s_wr_dat;
    logic [2:0]  wr_bx, s_wr_bx;
    logic [11:0] overflow, s_overflow;
    logic        err_tag, s_err_tag;

    int checks   = 0;
    int failures = 0;

    mem_demux #(.ADDR_W(6)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .BX             (bx),
        .mem_dat_stream (stream),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_dat         (wr_dat),
        .wr_bx          (wr_bx),
        .overflow       (overflow),
        .err_tag        (err_tag)
    );

    mem_demux #(.ADDR_W(2)) dut_s (
        .clk            (clk),
        .rst_n          (rst_n),
        .BX             (bx),
        .mem_dat_stream (stream),
        .wr_en          (s_wr_en),
        .wr_addr        (s_wr_addr),
        .wr_dat         (s_wr_dat),
        .wr_bx          (s_wr_bx),
        .overflow       (s_overflow),
        .err_tag        (s_err_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present one word for one capture edge, fill with idle, and return once its outputs are visible.
    task automatic send(input logic [3:0] t, input logic [43:0] p, input logic [2:0] b);
        @(negedge clk);
        stream = {t, p};
        bx     = b;
        @(posedge clk); #1;
        stream = {4'b0000, 44'h0};
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_en"},    64'(wr_en),    64'h0);
        check({tag, "_wr_addr"},  64'(wr_addr),  64'h0);
        check({tag, "_wr_dat"},   64'(wr_dat),   64'h0);
        check({tag, "_wr_bx"},    64'(wr_bx),    64'h0);
        check({tag, "_overflow"}, 64'(overflow), 64'h0);
        check({tag, "_err_tag"},  64'(err_tag),  64'h0);
    endtask

    initial begin
        rst_n  = 1'b0;
        bx     = 3'd0;
        stream = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;

        send(4'b0001, 44'h123, 3'd0);
        check("t1_en",   64'(wr_en),   64'h001);
        check("t1_addr", 64'(wr_addr), 64'h0);
        check("t1_dat",  64'(wr_dat),  64'h123);
        check("t1_bx",   64'(wr_bx),   64'h0);
        send(4'b0101, 44'h123, 3'd0);
        check("t5_en",   64'(wr_en),   64'h010);
        check("t5_addr", 64'(wr_addr), 64'h0);
        check("t5_dat",  64'(wr_dat),  64'h123);
        send(4'b1101, 44'h123, 3'd0);
        check("t13_en",   64'(wr_en),   64'h800);
        check("t13_addr", 64'(wr_addr), 64'h0);
        check("t13_dat",  64'(wr_dat),  64'h123);
        check("t13_bx",   64'(wr_bx),   64'h0);

        send(4'b1111, 44'hFFF, 3'd0);
        check("idle1_en",  64'(wr_en),   64'h0);
        check("idle1_err", 64'(err_tag), 64'h0);
        send(4'b0000, 44'hFFF, 3'd0);
        check("idle0_en",  64'(wr_en),   64'h0);
        check("idle0_err", 64'(err_tag), 64'h0);
        send(4'b1010, 44'hFFF, 3'd0);
        check("ill10_en",  64'(wr_en),   64'h0);
        check("ill10_err", 64'(err_tag), 64'h1);
        @(posedge clk); #1;
        check("ill10_err_after", 64'(err_tag), 64'h0);
        send(4'b1110, 44'hFFF, 3'd0);
        check("ill14_en",  64'(wr_en),   64'h0);
        check("ill14_err", 64'(err_tag), 64'h1);
        @(posedge clk); #1;
        check("ill14_err_after", 64'(err_tag), 64'h0);

        for (int i = 0; i < 5; i++) begin
            send(4'b1001, 44'(i + 16), 3'd3);
            if (i < 4) begin
                check("ovf_s_en",   64'(s_wr_en),    64'h100);
                check("ovf_s_addr", 64'(s_wr_addr),  64'(i));
                check("ovf_s_flag", 64'(s_overflow), 64'h0);
                check("ovf_s_bx",   64'(s_wr_bx),    64'h3);
            end else begin
                check("ovf_s_drop_en", 64'(s_wr_en),    64'h0);
                check("ovf_s_set",     64'(s_overflow), 64'h100);
                check("ovf_l_en",      64'(wr_en),      64'h100);
                check("ovf_l_addr",    64'(wr_addr),    64'h4);
                check("ovf_l_flag",    64'(overflow),   64'h0);
            end
        end
        @(posedge clk); #1;
        check("ovf_s_sticky", 64'(s_overflow), 64'h100);

        send(4'b1001, 44'hABC, 3'd4);
        check("nbx_s_en",   64'(s_wr_en),    64'h100);
        check("nbx_s_addr", 64'(s_wr_addr),  64'h0);
        check("nbx_s_dat",  64'(s_wr_dat),   64'hABC);
        check("nbx_s_ovf",  64'(s_overflow), 64'h0);
        check("nbx_s_bx",   64'(s_wr_bx),    64'h4);

        for (int i = 0; i < 3; i++) begin
            send(4'b1011, 44'(i + 32), 3'd1);
            check("pre_rst_en",   64'(wr_en),   64'h200);
            check("pre_rst_addr", 64'(wr_addr), 64'(i));
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        send(4'b1011, 44'h77, 3'd1);
        check("post_rst_en",   64'(wr_en),   64'h200);
        check("post_rst_addr", 64'(wr_addr), 64'h0);
        check("post_rst_dat",  64'(wr_dat),  64'h77);
        check("post_rst_bx",   64'(wr_bx),   64'h1);

        for (int k = 0; k < 10; k++) begin
            send((k % 2 == 1) ? 4'b0010 : 4'b0001, 44'(k + 100), 3'd5);
            check("alt_en",   64'(wr_en),   (k % 2 == 1) ? 64'h002 : 64'h001);
            check("alt_addr", 64'(wr_addr), 64'(k / 2));
            check("alt_dat",  64'(wr_dat),  64'(k + 100));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
